// File: rtl/aes_inv_cipher_core.sv
// ============================================================================
// Module      : aes_inv_cipher_core
// Description : Iterative AES-128 inverse cipher (decryption), one round per
//               clock. Accepts a ciphertext block on a valid/ready handshake.
//               Fetches round keys from external key-expansion storage via
//               rk_idx/rk_in. Returns the plaintext on a second valid/ready
//               handshake.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               ct_in, in_valid,
//               in_ready           - ciphertext input handshake
//               rk_idx, rk_in      - round-key request (combinational return)
//               pt_out, out_valid,
//               out_ready          - plaintext output handshake
//               abort              - only with AES_INV_ABORT_EN defined
// Option      : `define AES_INV_ABORT_EN adds the abort input
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_inv_cipher_core (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] ct_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic [127:0] pt_out,
    output logic         out_valid,
    input  logic         out_ready
`ifdef AES_INV_ABORT_EN
    ,
    input  logic         abort
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST_KEY = 4'd10;

    // ------------------------------------------------------------------
    // GF(2^8) helpers, modulus 0x11B
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0) via an addition chain.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] t;
        t = gf_mul(gf_mul(x, x), x);          // x^3
        t = gf_mul(gf_mul(t, t), x);          // x^7
        t = gf_mul(gf_mul(t, t), x);          // x^15
        t = gf_mul(gf_mul(t, t), x);          // x^31
        t = gf_mul(gf_mul(t, t), x);          // x^63
        t = gf_mul(gf_mul(t, t), x);          // x^127
        return gf_mul(t, t);                  // x^254
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // ------------------------------------------------------------------
    // Registers and datapath
    // ------------------------------------------------------------------
    state_t       r_fsm,   w_fsm_nxt;
    logic [127:0] r_state, w_state_nxt;
    logic [3:0]   r_round, w_round_nxt;
    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_mix;
    logic         w_abort;

`ifdef AES_INV_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // InvShiftRows + InvSubBytes: output (row, col) takes input byte from
    // column (col - row) mod 4, i.e. each row rotates right by its index.
    always_comb begin
        w_isb = '0;
        for (int col = 0; col < 4; col++) begin
            for (int row = 0; row < 4; row++) begin
                w_isb[127 - 8*(4*col + row) -: 8] =
                    inv_sbox(r_state[127 - 8*(4*((col + 4 - row) % 4) + row) -: 8]);
            end
        end
    end

    assign w_ark = w_isb ^ rk_in;

    always_comb begin
        w_mix = '0;
        for (int col = 0; col < 4; col++) begin
            w_mix[127 - 32*col -: 32] = inv_mix_col(w_ark[127 - 32*col -: 32]);
        end
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_round <= 4'd0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        rk_idx      = 4'd0;
        case (r_fsm)
            ST_IDLE: begin
                in_ready = 1'b1;
                rk_idx   = c_LAST_KEY;
                if (in_valid) begin
                    w_state_nxt = ct_in ^ rk_in;
                    w_round_nxt = 4'd9;
                    w_fsm_nxt   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rk_idx      = r_round;
                w_state_nxt = w_mix;
                w_round_nxt = r_round - 4'd1;
                if (r_round == 4'd1) w_fsm_nxt = ST_FINAL;
            end
            ST_FINAL: begin
                w_state_nxt = w_ark;
                w_fsm_nxt   = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_nxt = ST_IDLE;
            end
            default: w_fsm_nxt = ST_IDLE;
        endcase
        // Abort discards the in-flight block; never acts in IDLE.
        if (w_abort && (r_fsm != ST_IDLE)) begin
            w_fsm_nxt   = ST_IDLE;
            w_state_nxt = '0;
            w_round_nxt = 4'd0;
        end
    end

    // Intermediate round state is not exposed on the output bus.
    assign pt_out = (r_fsm == ST_DONE) ? r_state : '0;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_cipher_core.sv
// ============================================================================
// Module      : tb_aes_inv_cipher_core
// Description : Directed self-checking bench for aes_inv_cipher_core using
//               FIPS-197 vectors; models the round-key storage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_aes_inv_cipher_core;

    localparam logic [127:0] c_KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] ct_in;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk_in;
    logic [127:0] pt_out;
    logic         out_valid;
    logic         out_ready;
    logic         abort;

    logic [127:0] rk_a [0:15];
    logic [127:0] rk_b [0:15];
    logic         keysel;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb rk_in = keysel ? rk_b[rk_idx] : rk_a[rk_idx];

    aes_inv_cipher_core dut (
        .clk       (clk),
        .rst       (rst),
        .ct_in     (ct_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rk_idx    (rk_idx),
        .rk_in     (rk_in),
        .pt_out    (pt_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef AES_INV_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    // ---------------- reference key expansion ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: inverse found by search, then the FIPS affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        res = '0;
        for (int k = 0; k < 11; k++)
            res[1407 - 128*k -: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return res;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One block with out_ready high; optionally checks the rk_idx sequence.
    task automatic run_block(input string tag, input logic [127:0] ct,
                             input logic [127:0] exp, input bit chk_rk);
        logic [43:0] seq;
        int          j;
        bit          got;
        @(negedge clk);
        check({tag, " in_ready before accept"}, {127'h0, in_ready}, 128'd1);
        ct_in     = ct;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        seq       = {40'h0, rk_idx};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        ct_in    = {$urandom, $urandom, $urandom, $urandom};
        j   = 0;
        got = 1'b0;
        while (j < 20 && !got) begin
            if (out_valid) got = 1'b1;
            else begin
                seq = {seq[39:0], rk_idx};
                j++;
                @(negedge clk);
            end
        end
        check({tag, " latency"}, 128'(j), 128'd10);
        if (chk_rk) check({tag, " rk_idx sequence"}, {84'h0, seq}, 128'h0A9876543210);
        check({tag, " pt_out"}, pt_out, exp);
        @(negedge clk);
        check({tag, " out_valid after handshake"}, {127'h0, out_valid}, 128'd0);
        check({tag, " in_ready after handshake"}, {127'h0, in_ready}, 128'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1407:0] ka;
        logic [1407:0] kb;
        int            k2;
        int            nv;
        int            t1;
        bit            prev;
        bit            found;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ct_in = '0;
        abort = 1'b0; keysel = 1'b0;
        ka = expand(c_KEY_C1);
        kb = expand(c_KEY_B);
        for (int k = 0; k < 16; k++) begin
            rk_a[k] = (k < 11) ? ka[1407 - 128*k -: 128] : '0;
            rk_b[k] = (k < 11) ? kb[1407 - 128*k -: 128] : '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready",  {127'h0, in_ready},  128'd1);
        check("reset out_valid", {127'h0, out_valid}, 128'd0);
        check("reset pt_out",    pt_out,              128'd0);
        check("reset rk_idx",    {124'h0, rk_idx},    128'd10);
        rst = 1'b0;

        // FIPS-197 C.1 and Appendix B
        keysel = 1'b0;
        run_block("C1", c_CT_C1, c_PT_C1, 1'b0);
        keysel = 1'b1;
        run_block("B", c_CT_B, c_PT_B, 1'b1);

        // Backpressure
        keysel = 1'b0;
        @(negedge clk);
        ct_in = c_CT_C1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ct_in = c_CT_B;  // in_valid stays high and must be ignored
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (out_valid) found = 1'b1; else @(negedge clk);
        end
        check("bp out_valid seen", {127'h0, found}, 128'd1);
        for (int k = 0; k < 20; k++) begin
            check("bp pt_out stable", pt_out, c_PT_C1);
            check("bp in_ready low", {127'h0, in_ready}, 128'd0);
            @(negedge clk);
        end
        check("bp out_valid held", {127'h0, out_valid}, 128'd1);
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("bp out_valid drop", {127'h0, out_valid}, 128'd0);
        check("bp in_ready rise",  {127'h0, in_ready},  128'd1);

        // Mid-operation reset during round 5
        @(negedge clk);
        ct_in = c_CT_C1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (rk_idx == 4'd5 && !in_ready) found = 1'b1; else @(negedge clk);
        end
        check("rst reached round 5", {127'h0, found}, 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst in_ready",  {127'h0, in_ready},  128'd1);
        check("rst out_valid", {127'h0, out_valid}, 128'd0);
        check("rst rk_idx",    {124'h0, rk_idx},    128'd10);
        run_block("C1 after rst", c_CT_C1, c_PT_C1, 1'b0);

        // Back-to-back with in_valid held high
        keysel = 1'b0;
        @(negedge clk);
        ct_in = c_CT_C1; in_valid = 1'b1; out_ready = 1'b1;
        nv = 0; prev = 1'b0; t1 = 0;
        for (int k = 0; k < 60 && nv < 2; k++) begin
            @(negedge clk);
            if (out_valid && !prev) begin
                if (nv == 0) begin
                    check("b2b first pt", pt_out, c_PT_C1);
                    t1 = cyc;
                    keysel = 1'b1;
                    ct_in  = c_CT_B;
                end else begin
                    check("b2b second pt", pt_out, c_PT_B);
                    check("b2b spacing", 128'(cyc - t1), 128'd12);
                    in_valid = 1'b0;
                end
                nv++;
            end
            prev = out_valid;
        end
        check("b2b block count", 128'(nv), 128'd2);
        in_valid = 1'b0;
        @(negedge clk);
        keysel = 1'b0;

`ifdef AES_INV_ABORT_EN
        // Abort in FINAL
        @(negedge clk);
        ct_in = c_CT_C1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (rk_idx == 4'd0 && !out_valid && !in_ready) found = 1'b1; else @(negedge clk);
        end
        check("abort reached FINAL", {127'h0, found}, 128'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort in_ready", {127'h0, in_ready}, 128'd1);
        k2 = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) k2++;
            @(negedge clk);
        end
        check("abort no out_valid", 128'(k2), 128'd0);
        run_block("C1 after abort", c_CT_C1, c_PT_C1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
